pkt_gen_param: RTL and testbench

Parametrised successor to the single-mode test-packet source feeding the 10G link's user TX interface in the usclk domain.
- Generates back-to-back or gapped packets of fixed or sweeping length.
- Each packet carries a header with magic, length and sequence number, followed by an incrementing or LFSR payload.
- Supports a packet-count limit with done indication.
- Uses the same tx_ready / tx_data_en / sop / eop / byte_vaild handshake as the link TX port.

---
 rtl/pkt_gen_pkg.sv | 32 +++
 rtl/pkt_gen_lfsr.sv | 35 +++
 rtl/pkt_gen_param.sv | 253 +++++++++++++++++++++++++
 tb/tb_pkt_gen_param.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_gen_pkg.sv
// Shared definitions for the parametrised test-packet generator.
//   state_t      : generator FSM states
//   PKT_MAGIC    : header magic in beat 0 bits [15:0]
//   MIN_LEN      : shortest legal packet (the 8-byte header)
//   LFSR_POLY    : Galois mask for x^32+x^22+x^2+x+1 (right-shifting form)
//   LFSR_SEED    : LFSR value after reset
//   LEN_* / PAY_*: encodings of cfg_len_mode / cfg_pay_mode
package pkt_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] PKT_MAGIC = 16'hA55A;
  localparam int          MIN_LEN   = 8;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

  localparam logic LEN_FIXED = 1'b0;
  localparam logic LEN_SWEEP = 1'b1;
  localparam logic PAY_INC   = 1'b0;
  localparam logic PAY_LFSR  = 1'b1;

  // One Galois step: shift right, fold the taps in when a 1 falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/pkt_gen_lfsr.sv
// Parallel 32-bit Galois LFSR.
//   sys_clk, sys_rst : clock, synchronous active-high reset (state -> LFSR_SEED)
//   adv              : advance the state by NUM_WORDS steps
//   words            : words[k] = state stepped k times; word 0 is the current state
module pkt_gen_lfsr
  import pkt_gen_pkg::*;
#(
  parameter int NUM_WORDS = 2
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        adv,
  output logic [NUM_WORDS-1:0][31:0]  words
);

  logic [31:0] state;
  logic [31:0] state_n;

  always_comb begin
    logic [31:0] s;
    words = '0;
    s     = state;
    for (int k = 0; k < NUM_WORDS; k++) begin
      words[k] = s;
      s        = lfsr_step(s);
    end
    state_n = s;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)  state <= LFSR_SEED;
    else if (adv) state <= state_n;
  end

endmodule

// File: rtl/pkt_gen_param.sv
// Parametrised test-packet source for a link TX port (tx_ready / tx_data_en
// handshake). Packets: 8-byte header {seq[31:0], len[15:0], magic} followed by
// incrementing-byte or LFSR payload, fixed or sweeping length, optional gap,
// optional packet-count limit.
//   sys_clk, sys_rst      : clock, synchronous active-high reset
//   cfg_*                 : run control, length/payload mode, lengths, gap, limit
//   tx_ready              : sink accepts the presented beat
//   tx_data/_en/_sop/_eop : registered beat outputs, held while stalled
//   tx_data_byte_vaild    : valid-byte mask of the presented beat
//   busy, done, pkt_cnt   : status
//   stat_bytes/stat_stall : traffic counters, present only when the
//                           PKT_GEN_STATS_EN macro is defined (else tied to 0)
module pkt_gen_param
  import pkt_gen_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 16,
  parameter int GAP_W  = 8,
  parameter int CNT_W  = 32
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cfg_enable,
  input  logic                cfg_len_mode,
  input  logic                cfg_pay_mode,
  input  logic [LEN_W-1:0]    cfg_len_min,
  input  logic [LEN_W-1:0]    cfg_len_max,
  input  logic [GAP_W-1:0]    cfg_gap,
  input  logic [CNT_W-1:0]    cfg_pkt_limit,
  input  logic                tx_ready,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_data_en,
  output logic                tx_data_sop,
  output logic                tx_data_eop,
  output logic [DATA_W/8-1:0] tx_data_byte_vaild,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pkt_cnt,
  output logic [CNT_W-1:0]    stat_bytes,
  output logic [CNT_W-1:0]    stat_stall
);

  localparam int KEEP_W    = DATA_W / 8;
  localparam int NUM_WORDS = DATA_W / 32;

  if (DATA_W < 64 || (DATA_W % 64) != 0) begin : g_bad_width
    $error("pkt_gen_param: DATA_W must be a multiple of 64");
  end

  state_t            state, state_n;
  logic [GAP_W-1:0]  gap_cnt;
  logic [CNT_W-1:0]  seq;
  logic [LEN_W-1:0]  sweep_len;   // raw length the next sweeping packet uses
  logic [LEN_W-1:0]  pkt_raw;     // raw (unclamped) length of the packet in flight
  logic [LEN_W-1:0]  pkt_len;     // L of the packet in flight
  logic              pkt_pay;
  logic [LEN_W-1:0]  rem;         // bytes left including the presented beat
  logic [7:0]        base;        // low byte of the presented beat's first byte index

  logic fire, last, launch, step, rearm, limit_hit;
  logic [CNT_W-1:0] cnt_inc;

  assign fire      = tx_data_en & tx_ready;
  assign last      = fire & tx_data_eop;
  assign cnt_inc   = pkt_cnt + CNT_W'(1);
  assign limit_hit = (cfg_pkt_limit != '0) && (cnt_inc == cfg_pkt_limit);
  assign rearm     = (state == DONE) && !cfg_enable;
  assign busy      = (state == DATA) || (state == GAP);
  assign done      = (state == DONE);

  // ---------------- FSM ----------------
  // launch: present the sop beat of a new packet on the next cycle.
  // step  : present the next beat of the current packet.
  always_comb begin
    state_n = state;
    launch  = 1'b0;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        // done is only ever high in DONE, so enable alone starts a run here
        if (cfg_enable) begin
          state_n = DATA;
          launch  = 1'b1;
        end
      end
      DATA: begin
        if (fire) begin
          if (!tx_data_eop)                      step    = 1'b1;
          else if (limit_hit)                    state_n = DONE;
          else if (cfg_gap == '0 && cfg_enable)  launch  = 1'b1;
          else if (cfg_gap != '0)                state_n = GAP;
          else                                   state_n = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt <= GAP_W'(1)) begin
          if (cfg_enable) begin
            state_n = DATA;
            launch  = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DONE: begin
        if (!cfg_enable) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------- length selection ----------------
  // On a back-to-back launch the sweep register is updated on the same edge,
  // so the new packet must see the advanced value directly.
  logic [LEN_W-1:0] sweep_adv, sweep_cur, sel_raw, new_len;

  always_comb begin
    sweep_adv = (pkt_raw >= cfg_len_max) ? cfg_len_min : pkt_raw + LEN_W'(1);
    sweep_cur = last ? sweep_adv : sweep_len;
    sel_raw   = cfg_len_min;
    if (cfg_len_mode == LEN_SWEEP && cfg_len_max >= cfg_len_min &&
        sweep_cur >= cfg_len_min && sweep_cur <= cfg_len_max)
      sel_raw = sweep_cur;
    new_len = (sel_raw < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : sel_raw;
  end

  // ---------------- next-beat builder ----------------
  logic              nb_first, nb_pay, nb_eop;
  logic [LEN_W-1:0]  nb_len, nb_rem;
  logic [7:0]        nb_base;
  logic [CNT_W-1:0]  nb_seq;
  logic [63:0]       hdr;
  logic [DATA_W-1:0] nb_data;
  logic [KEEP_W-1:0] nb_mask;
  logic [NUM_WORDS-1:0][31:0] lfsr_words;

  always_comb begin
    if (launch) begin
      nb_first = 1'b1;
      nb_len   = new_len;
      nb_rem   = new_len;
      nb_base  = 8'h00;
      nb_pay   = cfg_pay_mode;
    end else begin
      nb_first = 1'b0;
      nb_len   = pkt_len;
      nb_rem   = rem - LEN_W'(KEEP_W);
      nb_base  = base + 8'(KEEP_W);
      nb_pay   = pkt_pay;
    end
    nb_seq = last ? seq + CNT_W'(1) : seq;
    nb_eop = (nb_rem <= LEN_W'(KEEP_W));
    hdr    = {32'(nb_seq), 16'(nb_len), PKT_MAGIC};
  end

  for (genvar b = 0; b < KEEP_W; b++) begin : g_byte
    logic [7:0] hdr_b, val;
    logic       hdr_use;
    if (b < MIN_LEN) begin : g_h
      assign hdr_b   = hdr[b*8 +: 8];
      assign hdr_use = nb_first;
    end else begin : g_p
      assign hdr_b   = 8'h00;
      assign hdr_use = 1'b0;
    end
    always_comb begin
      if (hdr_use)                val = hdr_b;
      else if (nb_pay == PAY_LFSR) val = lfsr_words[b/4][(b%4)*8 +: 8];
      else                        val = nb_base + 8'(b);
    end
    assign nb_mask[b]         = (LEN_W'(b) < nb_rem);
    assign nb_data[b*8 +: 8]  = nb_mask[b] ? val : 8'h00;
  end

  // The LFSR walks every 32-bit lane of each LFSR-mode beat it fills, header
  // lanes included, so a word's value depends only on its position in the stream.
  pkt_gen_lfsr #(.NUM_WORDS(NUM_WORDS)) u_lfsr (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .adv     ((launch | step) && nb_pay == PAY_LFSR),
    .words   (lfsr_words)
  );

  // ---------------- registers ----------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state              <= IDLE;
      gap_cnt            <= '0;
      seq                <= '0;
      pkt_cnt            <= '0;
      sweep_len          <= cfg_len_min;
      pkt_raw            <= '0;
      pkt_len            <= '0;
      pkt_pay            <= 1'b0;
      rem                <= '0;
      base               <= '0;
      tx_data            <= '0;
      tx_data_en         <= 1'b0;
      tx_data_sop        <= 1'b0;
      tx_data_eop        <= 1'b0;
      tx_data_byte_vaild <= '0;
    end else begin
      state <= state_n;

      if (last)               gap_cnt <= cfg_gap;
      else if (state == GAP)  gap_cnt <= gap_cnt - GAP_W'(1);

      if (last) begin
        seq       <= seq + CNT_W'(1);
        pkt_cnt   <= cnt_inc;
        sweep_len <= sweep_adv;
      end else if (rearm) begin
        pkt_cnt   <= '0;
      end

      if (launch) pkt_raw <= sel_raw;

      if (launch | step) begin
        tx_data            <= nb_data;
        tx_data_en         <= 1'b1;
        tx_data_sop        <= nb_first;
        tx_data_eop        <= nb_eop;
        tx_data_byte_vaild <= nb_mask;
        rem                <= nb_rem;
        base               <= nb_base;
        pkt_len            <= nb_len;
        pkt_pay            <= nb_pay;
      end else if (last) begin
        tx_data            <= '0;
        tx_data_en         <= 1'b0;
        tx_data_sop        <= 1'b0;
        tx_data_eop        <= 1'b0;
        tx_data_byte_vaild <= '0;
      end
    end
  end

`ifdef PKT_GEN_STATS_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst || rearm) begin
      stat_bytes <= '0;
      stat_stall <= '0;
    end else begin
      if (fire)                     stat_bytes <= stat_bytes + CNT_W'($countones(tx_data_byte_vaild));
      if (tx_data_en && !tx_ready)  stat_stall <= stat_stall + CNT_W'(1);
    end
  end
`else
  assign stat_bytes = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_pkt_gen_param.sv
`timescale 1ns/1ps
module tb_pkt_gen_param;
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int LEN_W  = 16;
  localparam int GAP_W  = 8;
  localparam int CNT_W  = 32;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b0;
  logic              cfg_enable = 1'b0;
  logic              cfg_len_mode = 1'b0;
  logic              cfg_pay_mode = 1'b0;
  logic [LEN_W-1:0]  cfg_len_min = 16'd64;
  logic [LEN_W-1:0]  cfg_len_max = 16'd64;
  logic [GAP_W-1:0]  cfg_gap = '0;
  logic [CNT_W-1:0]  cfg_pkt_limit = '0;
  logic              tx_ready = 1'b1;
  logic [DATA_W-1:0] tx_data;
  logic              tx_data_en, tx_data_sop, tx_data_eop;
  logic [KEEP_W-1:0] tx_data_byte_vaild;
  logic              busy, done;
  logic [CNT_W-1:0]  pkt_cnt, stat_bytes, stat_stall;

  int checks = 0;
  int errors = 0;

  logic [63:0] cap_data[$];
  logic [7:0]  cap_mask[$];
  logic        cap_sop[$];
  logic        cap_eop[$];
  int          cap_gap[$];

  always #5 sys_clk = ~sys_clk;

  pkt_gen_param #(.DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_enable(cfg_enable),
    .cfg_len_mode(cfg_len_mode), .cfg_pay_mode(cfg_pay_mode),
    .cfg_len_min(cfg_len_min), .cfg_len_max(cfg_len_max), .cfg_gap(cfg_gap),
    .cfg_pkt_limit(cfg_pkt_limit), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_data_en(tx_data_en), .tx_data_sop(tx_data_sop), .tx_data_eop(tx_data_eop),
    .tx_data_byte_vaild(tx_data_byte_vaild), .busy(busy), .done(done),
    .pkt_cnt(pkt_cnt), .stat_bytes(stat_bytes), .stat_stall(stat_stall)
  );

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic setup(input logic lm, input logic pm, input int lmin, input int lmax,
                       input int gap, input int lim);
    cfg_enable    = 1'b0;
    cfg_len_mode  = lm;
    cfg_pay_mode  = pm;
    cfg_len_min   = LEN_W'(lmin);
    cfg_len_max   = LEN_W'(lmax);
    cfg_gap       = GAP_W'(gap);
    cfg_pkt_limit = CNT_W'(lim);
    tx_ready      = 1'b1;
    sys_rst       = 1'b1;
    tick;
    tick;
    sys_rst       = 1'b0;
  endtask

  // Records every transferred beat until npkts eops have gone by.
  task automatic capture(input int npkts, input int budget, output bit timeout);
    int pk, cyc, idle;
    pk = 0; cyc = 0; idle = 0; timeout = 1'b0;
    cap_data.delete(); cap_mask.delete(); cap_sop.delete(); cap_eop.delete(); cap_gap.delete();
    while (pk < npkts && !timeout) begin
      if (tx_data_en && tx_ready) begin
        if (tx_data_sop) begin
          cap_gap.push_back(idle);
          idle = 0;
        end
        cap_data.push_back(tx_data);
        cap_mask.push_back(tx_data_byte_vaild);
        cap_sop.push_back(tx_data_sop);
        cap_eop.push_back(tx_data_eop);
        if (tx_data_eop) pk++;
      end else if (!tx_data_en) begin
        idle++;
      end
      cyc++;
      if (cyc > budget) timeout = 1'b1;
      tick;
    end
  endtask

  task automatic test_reset;
    setup(1'b0, 1'b0, 64, 64, 0, 1);
    checks++;
    if (tx_data !== '0 || tx_data_en !== 1'b0 || tx_data_sop !== 1'b0 || tx_data_eop !== 1'b0 ||
        tx_data_byte_vaild !== '0 || busy !== 1'b0 || done !== 1'b0 || pkt_cnt !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h en=%b sop=%b eop=%b mask=%h busy=%b done=%b cnt=%0d, want all 0",
               tx_data, tx_data_en, tx_data_sop, tx_data_eop, tx_data_byte_vaild, busy, done, pkt_cnt);
    end
    checks++;
    if (stat_bytes !== '0 || stat_stall !== '0) begin
      errors++;
      $display("FAIL reset_stats: got bytes=%0d stall=%0d, want 0 0", stat_bytes, stat_stall);
    end
    cfg_enable = 1'b1;
    tick;
    checks++;
    if (tx_data_en !== 1'b1 || tx_data_sop !== 1'b1) begin
      errors++;
      $display("FAIL first_sop_latency: got en=%b sop=%b, want 1 1", tx_data_en, tx_data_sop);
    end
  endtask

  task automatic test_fixed;
    bit to;
    setup(1'b0, 1'b0, 64, 64, 0, 3);
    cfg_enable = 1'b1;
    capture(3, 200, to);
    checks++;
    if (to || cap_data.size() != 24) begin
      errors++;
      $display("FAIL fixed_beats: got %0d beats timeout=%b, want 24", cap_data.size(), to);
    end else begin
      checks++;
      if (cap_data[0] !== 64'h0000_0000_0040_A55A) begin
        errors++; $display("FAIL fixed_hdr0: got %h want %h", cap_data[0], 64'h0000_0000_0040_A55A);
      end
      checks++;
      if (cap_data[8] !== 64'h0000_0001_0040_A55A) begin
        errors++; $display("FAIL fixed_hdr1: got %h want %h", cap_data[8], 64'h0000_0001_0040_A55A);
      end
      checks++;
      if (cap_data[16] !== 64'h0000_0002_0040_A55A) begin
        errors++; $display("FAIL fixed_hdr2: got %h want %h", cap_data[16], 64'h0000_0002_0040_A55A);
      end
      checks++;
      if (cap_mask[7] !== 8'hFF || cap_eop[7] !== 1'b1 || cap_eop[6] !== 1'b0) begin
        errors++; $display("FAIL fixed_eop: got mask=%h eop7=%b eop6=%b, want ff 1 0", cap_mask[7], cap_eop[7], cap_eop[6]);
      end
      checks++;
      if (cap_gap[1] != 0 || cap_gap[2] != 0) begin
        errors++; $display("FAIL fixed_b2b: got gaps %0d %0d, want 0 0", cap_gap[1], cap_gap[2]);
      end
    end
    checks++;
    if (done !== 1'b1 || pkt_cnt !== 32'd3 || tx_data_en !== 1'b0) begin
      errors++; $display("FAIL fixed_done: got done=%b cnt=%0d en=%b, want 1 3 0", done, pkt_cnt, tx_data_en);
    end
    cfg_enable = 1'b0;
    tick;
    checks++;
    if (done !== 1'b0 || pkt_cnt !== '0) begin
      errors++; $display("FAIL fixed_rearm: got done=%b cnt=%0d, want 0 0", done, pkt_cnt);
    end
  endtask

  task automatic test_len67;
    bit to;
    setup(1'b0, 1'b0, 67, 67, 0, 1);
    cfg_enable = 1'b1;
    capture(1, 100, to);
    checks++;
    if (to || cap_data.size() != 9) begin
      errors++; $display("FAIL len67_beats: got %0d timeout=%b, want 9", cap_data.size(), to);
    end else begin
      checks++;
      if (cap_data[0] !== 64'h0000_0000_0043_A55A) begin
        errors++; $display("FAIL len67_hdr: got %h want %h", cap_data[0], 64'h0000_0000_0043_A55A);
      end
      checks++;
      if (cap_data[1] !== 64'h0F0E0D0C0B0A0908) begin
        errors++; $display("FAIL len67_beat1: got %h want %h", cap_data[1], 64'h0F0E0D0C0B0A0908);
      end
      checks++;
      if (cap_data[8] !== 64'h0000000000424140 || cap_mask[8] !== 8'h07) begin
        errors++; $display("FAIL len67_eop: got data=%h mask=%h, want 0000000000424140 07", cap_data[8], cap_mask[8]);
      end
      checks++;
      if (cap_eop[7] !== 1'b0 || cap_mask[7] !== 8'hFF) begin
        errors++; $display("FAIL len67_beat7: got eop=%b mask=%h, want 0 ff", cap_eop[7], cap_mask[7]);
      end
    end
  endtask

  task automatic test_stall;
    logic [3:0]  pat;
    logic [74:0] prev, cur;
    logic [63:0] expd;
    bit prev_stall, got_eop;
    int nb, stalls;
    pat = 4'b1001;  // ready sequence 1,0,0,1 read from bit 3 down
    prev = '0; prev_stall = 1'b0; got_eop = 1'b0; nb = 0; stalls = 0;
    setup(1'b0, 1'b0, 64, 64, 0, 1);
    cfg_enable = 1'b1;
    tick;
    for (int cyc = 0; cyc < 200 && !got_eop; cyc++) begin
      tx_ready = pat[3 - (cyc % 4)];
      cur = {tx_data, tx_data_sop, tx_data_eop, tx_data_byte_vaild, tx_data_en};
      if (prev_stall) begin
        checks++;
        if (cur !== prev) begin
          errors++; $display("FAIL stall_hold: cycle %0d got %h want %h", cyc, cur, prev);
        end
      end
      if (tx_data_en && tx_ready) begin
        if (nb == 0) expd = 64'h0000_0000_0040_A55A;
        else for (int b = 0; b < 8; b++) expd[b*8 +: 8] = 8'(nb*8 + b);
        checks++;
        if (tx_data !== expd || tx_data_sop !== (nb == 0)) begin
          errors++; $display("FAIL stall_beat%0d: got %h sop=%b want %h", nb, tx_data, tx_data_sop, expd);
        end
        nb++;
        if (tx_data_eop) got_eop = 1'b1;
      end
      prev_stall = tx_data_en && !tx_ready;
      if (prev_stall) stalls++;
      prev = cur;
      tick;
    end
    tx_ready = 1'b1;
    checks++;
    if (nb != 8 || !got_eop) begin
      errors++; $display("FAIL stall_count: got %0d beats eop=%b, want 8 1", nb, got_eop);
    end
`ifdef PKT_GEN_STATS_EN
    checks++;
    if (stat_stall !== CNT_W'(stalls) || stat_bytes !== 32'd64) begin
      errors++; $display("FAIL stall_stats: got stall=%0d bytes=%0d, want %0d 64", stat_stall, stat_bytes, stalls);
    end
`endif
  endtask

  task automatic test_sweep;
    bit to;
    int          lens[$];
    logic [7:0]  masks[$];
    int          exp_len[4];
    logic [7:0]  exp_mask[4];
    exp_len  = '{60, 61, 62, 60};
    exp_mask = '{8'h0F, 8'h1F, 8'h3F, 8'h0F};
    setup(1'b1, 1'b0, 60, 62, 0, 4);
    cfg_enable = 1'b1;
    capture(4, 300, to);
    for (int i = 0; i < cap_data.size(); i++) begin
      if (cap_sop[i]) lens.push_back(int'(cap_data[i][31:16]));
      if (cap_eop[i]) masks.push_back(cap_mask[i]);
    end
    checks++;
    if (to || lens.size() != 4 || masks.size() != 4) begin
      errors++; $display("FAIL sweep_pkts: got %0d hdrs %0d eops timeout=%b, want 4 4", lens.size(), masks.size(), to);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (lens[k] != exp_len[k] || masks[k] !== exp_mask[k]) begin
          errors++; $display("FAIL sweep_pkt%0d: got len=%0d mask=%h, want %0d %h", k, lens[k], masks[k], exp_len[k], exp_mask[k]);
        end
      end
    end
  endtask

  task automatic test_gap;
    bit to;
    setup(1'b0, 1'b0, 16, 16, 5, 3);
    cfg_enable = 1'b1;
    capture(3, 200, to);
    checks++;
    if (to || cap_gap.size() != 3) begin
      errors++; $display("FAIL gap_pkts: got %0d sops timeout=%b, want 3", cap_gap.size(), to);
    end else begin
      checks++;
      if (cap_gap[1] != 5 || cap_gap[2] != 5) begin
        errors++; $display("FAIL gap_len: got %0d %0d idle cycles, want 5 5", cap_gap[1], cap_gap[2]);
      end
    end
  endtask

  task automatic test_lfsr;
    bit to;
    setup(1'b0, 1'b1, 16, 16, 0, 1);
    cfg_enable = 1'b1;
    capture(1, 100, to);
    checks++;
    if (to || cap_data.size() != 2) begin
      errors++; $display("FAIL lfsr_beats: got %0d timeout=%b, want 2", cap_data.size(), to);
    end else begin
      checks++;
      if (cap_data[0] !== 64'h0000_0000_0010_A55A || cap_data[1] !== 64'h3FF7FFFF_7FEFFFFE) begin
        errors++; $display("FAIL lfsr_data: got %h %h, want 000000000010a55a 3ff7ffff7feffffe", cap_data[0], cap_data[1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int bidx, nbeats;
    logic [31:0] cur_seq;
    bit hit, got;
    bidx = 0; cur_seq = '0; hit = 1'b0;
    setup(1'b0, 1'b0, 32, 32, 0, 0);
    cfg_enable = 1'b1;
    for (int c = 0; c < 400 && !hit; c++) begin
      if (tx_data_en) begin
        if (tx_data_sop) begin bidx = 0; cur_seq = tx_data[63:32]; end
        else bidx++;
      end
      if (tx_data_en && cur_seq == 32'd7 && bidx == 3) hit = 1'b1;
      else tick;
    end
    checks++;
    if (!hit || pkt_cnt !== 32'd7) begin
      errors++; $display("FAIL rstmid_reach: got hit=%b cnt=%0d, want 1 7", hit, pkt_cnt);
    end
    sys_rst = 1'b1;
    tick;
    checks++;
    if (tx_data !== '0 || tx_data_en !== 1'b0 || tx_data_sop !== 1'b0 || tx_data_eop !== 1'b0 ||
        tx_data_byte_vaild !== '0 || busy !== 1'b0 || done !== 1'b0 || pkt_cnt !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got data=%h en=%b mask=%h busy=%b cnt=%0d, want all 0",
               tx_data, tx_data_en, tx_data_byte_vaild, busy, pkt_cnt);
    end
    sys_rst = 1'b0;
    for (int c = 0; c < 5 && !tx_data_sop; c++) tick;
    checks++;
    if (tx_data_sop !== 1'b1 || tx_data[63:32] !== 32'd0) begin
      errors++; $display("FAIL rstmid_seq: got sop=%b seq=%0d, want 1 0", tx_data_sop, tx_data[63:32]);
    end
    nbeats = 0; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (tx_data_en) nbeats++;
      if (tx_data_en && tx_data_eop) got = 1'b1;
      if (c == 1) cfg_enable = 1'b0;
      tick;
    end
    checks++;
    if (!got || nbeats != 4 || tx_data_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL disable_mid: got eop=%b beats=%0d en=%b busy=%b, want 1 4 0 0", got, nbeats, tx_data_en, busy);
    end
    tick; tick; tick;
    checks++;
    if (tx_data_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL disable_idle: got en=%b busy=%b, want 0 0", tx_data_en, busy);
    end
  endtask

  initial begin
    test_reset;
    test_fixed;
    test_len67;
    test_stall;
    test_sweep;
    test_gap;
    test_lfsr;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
